// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//
// Shared definitions for the pipelined radix-2 butterfly:
//   MODE_DIT / MODE_DIF : values of the per-sample mode bit.
//   round_shift()       : arithmetic right shift with round-half-up.
//   saturate()          : clamp a signed value into a signed field of a given width.
//
// Both helpers work on 64-bit signed values so callers can hand them any
// intermediate result without first deciding on a width.
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam logic MODE_DIT = 1'b0;
    localparam logic MODE_DIF = 1'b1;

    // (value + 2^(sh-1)) >>> sh; a zero shift passes the value through.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] value,
                                                       input int unsigned        sh);
        logic signed [63:0] bias;
        round_shift = value;
        if (sh != 0) begin
            bias        = 64'sd1 <<< (sh - 1);
            round_shift = (value + bias) >>> sh;
        end
    endfunction

    // Clamp to [-2^(width-1), 2^(width-1)-1].
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int unsigned        width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            saturate = hi;
        end else if (value < lo) begin
            saturate = lo;
        end else begin
            saturate = value;
        end
    endfunction

endpackage

// File: rtl/fft_cmul_round.sv
// ---------------------------------------------------------------------------
// fft_cmul_round
//
// Combinational complex multiply with round-half-up on the result.
//   x_re_i, x_im_i : WIDTH+1-bit signed multiplicand (wide enough for a DIF
//                    difference)
//   w_re_i, w_im_i : WIDTH-bit signed twiddle, FRAC fractional bits
//   p_re_o, p_im_o : (x*w + 2^(FRAC-1)) >>> FRAC, 2*WIDTH+2-FRAC bits signed
//
// Products are formed at 2*WIDTH+2 bits, which holds the worst-case sum of
// two (WIDTH+1)x(WIDTH) products, so nothing is lost before rounding.
// ---------------------------------------------------------------------------
module fft_cmul_round
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FRAC  = 4
) (
    input  logic [WIDTH:0]            x_re_i,
    input  logic [WIDTH:0]            x_im_i,
    input  logic [WIDTH-1:0]          w_re_i,
    input  logic [WIDTH-1:0]          w_im_i,
    output logic [2*WIDTH+1-FRAC:0]   p_re_o,
    output logic [2*WIDTH+1-FRAC:0]   p_im_o
);

    localparam int unsigned PW = 2 * WIDTH + 2;
    localparam int unsigned RW = PW - FRAC;

    logic signed [PW-1:0] xr;
    logic signed [PW-1:0] xi;
    logic signed [PW-1:0] wr;
    logic signed [PW-1:0] wi;
    logic signed [PW-1:0] prod_re;
    logic signed [PW-1:0] prod_im;

    always_comb begin
        xr      = PW'($signed(x_re_i));
        xi      = PW'($signed(x_im_i));
        wr      = PW'($signed(w_re_i));
        wi      = PW'($signed(w_im_i));
        prod_re = (xr * wr) - (xi * wi);
        prod_im = (xr * wi) + (xi * wr);
        // After dropping FRAC bits the rounded value fits in RW bits.
        p_re_o  = RW'(round_shift(64'(prod_re), FRAC));
        p_im_o  = RW'(round_shift(64'(prod_im), FRAC));
    end

endmodule

// File: rtl/fft_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// fft_butterfly_pipe
//
// Three-stage pipelined radix-2 butterfly, DIT or DIF selected per sample.
//   DIT: m = B*W;  o0 = A + m;  o1 = A - m
//   DIF: d = A - B; o0 = A + B; o1 = d*W
// Multiplies are rounded half-up, optional per-sample 1/2 scaling (rounded),
// then each output is saturated to WIDTH bits.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      input handshake (in_ready is combinational)
//   in_mode                  0 = DIT, 1 = DIF (travels with the sample)
//   in_scale                 1 = halve each output before saturation
//   in_ar/ai, in_br/bi       operands A and B, WIDTH-bit signed
//   in_wr/wi                 twiddle, Q(WIDTH-FRAC).FRAC
//   out_valid / out_ready    output handshake
//   out_0r/0i, out_1r/1i     butterfly results, WIDTH-bit signed
//   out_sat                  some output of this result was clipped
//   sat_sticky               OR of every handshaked out_sat since reset
//
// Stages
//   S1: register inputs, DIF difference, choose the multiplicand
//   S2: complex multiply + rounding
//   S3: final add/sub, scale, saturate, out_sat
// The whole pipe stalls together: advance = !out_valid | out_ready.
// ---------------------------------------------------------------------------
module fft_butterfly_pipe
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FRAC  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic             in_scale,
    input  logic [WIDTH-1:0] in_ar,
    input  logic [WIDTH-1:0] in_ai,
    input  logic [WIDTH-1:0] in_br,
    input  logic [WIDTH-1:0] in_bi,
    input  logic [WIDTH-1:0] in_wr,
    input  logic [WIDTH-1:0] in_wi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_0r,
    output logic [WIDTH-1:0] out_0i,
    output logic [WIDTH-1:0] out_1r,
    output logic [WIDTH-1:0] out_1i,
    output logic             out_sat,
    output logic             sat_sticky
);

    // Width of the rounded product.
    localparam int unsigned RW = 2 * WIDTH + 2 - FRAC;

    logic advance;

    // ---------------- S1 state ----------------
    logic             s1_valid_q, s1_valid_d;
    logic             s1_mode_q,  s1_mode_d;
    logic             s1_scale_q, s1_scale_d;
    logic [WIDTH-1:0] s1_ar_q, s1_ar_d;
    logic [WIDTH-1:0] s1_ai_q, s1_ai_d;
    logic [WIDTH-1:0] s1_br_q, s1_br_d;
    logic [WIDTH-1:0] s1_bi_q, s1_bi_d;
    logic [WIDTH-1:0] s1_wr_q, s1_wr_d;
    logic [WIDTH-1:0] s1_wi_q, s1_wi_d;
    logic [WIDTH:0]   s1_xr_q, s1_xr_d;
    logic [WIDTH:0]   s1_xi_q, s1_xi_d;

    // ---------------- S2 state ----------------
    logic             s2_valid_q, s2_valid_d;
    logic             s2_mode_q,  s2_mode_d;
    logic             s2_scale_q, s2_scale_d;
    logic [WIDTH-1:0] s2_ar_q, s2_ar_d;
    logic [WIDTH-1:0] s2_ai_q, s2_ai_d;
    logic [WIDTH-1:0] s2_br_q, s2_br_d;
    logic [WIDTH-1:0] s2_bi_q, s2_bi_d;
    logic [RW-1:0]    s2_mr_q, s2_mr_d;
    logic [RW-1:0]    s2_mi_q, s2_mi_d;

    // ---------------- S3 / output state ----------------
    logic             out_valid_q,  out_valid_d;
    logic [WIDTH-1:0] out_0r_q, out_0r_d;
    logic [WIDTH-1:0] out_0i_q, out_0i_d;
    logic [WIDTH-1:0] out_1r_q, out_1r_d;
    logic [WIDTH-1:0] out_1i_q, out_1i_d;
    logic             out_sat_q,    out_sat_d;
    logic             sat_sticky_q, sat_sticky_d;

    // ---------------- S1 combinational ----------------
    logic [WIDTH:0] in_br_ext, in_bi_ext;
    logic [WIDTH:0] dif_r, dif_i;

    always_comb begin
        in_br_ext = {in_br[WIDTH-1], in_br};
        in_bi_ext = {in_bi[WIDTH-1], in_bi};
        // Sign-extended to WIDTH+1 bits, so A - B cannot overflow.
        dif_r     = {in_ar[WIDTH-1], in_ar} - in_br_ext;
        dif_i     = {in_ai[WIDTH-1], in_ai} - in_bi_ext;
    end

    // ---------------- S2 multiplier ----------------
    logic [RW-1:0] mul_re, mul_im;

    fft_cmul_round #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_cmul (
        .x_re_i (s1_xr_q),
        .x_im_i (s1_xi_q),
        .w_re_i (s1_wr_q),
        .w_im_i (s1_wi_q),
        .p_re_o (mul_re),
        .p_im_o (mul_im)
    );

    // ---------------- S3 combinational ----------------
    logic signed [63:0] a_r, a_i, b_r, b_i, m_r, m_i;
    logic signed [63:0] r0r, r0i, r1r, r1i;
    logic signed [63:0] s0r, s0i, s1r, s1i;
    logic               s3_clip;

    always_comb begin
        a_r = 64'($signed(s2_ar_q));
        a_i = 64'($signed(s2_ai_q));
        b_r = 64'($signed(s2_br_q));
        b_i = 64'($signed(s2_bi_q));
        m_r = 64'($signed(s2_mr_q));
        m_i = 64'($signed(s2_mi_q));

        if (s2_mode_q == MODE_DIT) begin
            r0r = a_r + m_r;
            r0i = a_i + m_i;
            r1r = a_r - m_r;
            r1i = a_i - m_i;
        end else begin
            r0r = a_r + b_r;
            r0i = a_i + b_i;
            r1r = m_r;
            r1i = m_i;
        end

        if (s2_scale_q) begin
            r0r = round_shift(r0r, 1);
            r0i = round_shift(r0i, 1);
            r1r = round_shift(r1r, 1);
            r1i = round_shift(r1i, 1);
        end

        s0r     = saturate(r0r, WIDTH);
        s0i     = saturate(r0i, WIDTH);
        s1r     = saturate(r1r, WIDTH);
        s1i     = saturate(r1i, WIDTH);
        s3_clip = (s0r != r0r) || (s0i != r0i) || (s1r != r1r) || (s1i != r1i);
    end

    // ---------------- next-state ----------------
    always_comb begin
        advance = !out_valid_q || out_ready;

        s1_valid_d   = s1_valid_q;
        s1_mode_d    = s1_mode_q;
        s1_scale_d   = s1_scale_q;
        s1_ar_d      = s1_ar_q;
        s1_ai_d      = s1_ai_q;
        s1_br_d      = s1_br_q;
        s1_bi_d      = s1_bi_q;
        s1_wr_d      = s1_wr_q;
        s1_wi_d      = s1_wi_q;
        s1_xr_d      = s1_xr_q;
        s1_xi_d      = s1_xi_q;

        s2_valid_d   = s2_valid_q;
        s2_mode_d    = s2_mode_q;
        s2_scale_d   = s2_scale_q;
        s2_ar_d      = s2_ar_q;
        s2_ai_d      = s2_ai_q;
        s2_br_d      = s2_br_q;
        s2_bi_d      = s2_bi_q;
        s2_mr_d      = s2_mr_q;
        s2_mi_d      = s2_mi_q;

        out_valid_d  = out_valid_q;
        out_0r_d     = out_0r_q;
        out_0i_d     = out_0i_q;
        out_1r_d     = out_1r_q;
        out_1i_d     = out_1i_q;
        out_sat_d    = out_sat_q;

        sat_sticky_d = sat_sticky_q || (out_valid_q && out_ready && out_sat_q);

        if (advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_mode_d  = in_mode;
                s1_scale_d = in_scale;
                s1_ar_d    = in_ar;
                s1_ai_d    = in_ai;
                s1_br_d    = in_br;
                s1_bi_d    = in_bi;
                s1_wr_d    = in_wr;
                s1_wi_d    = in_wi;
                s1_xr_d    = (in_mode == MODE_DIF) ? dif_r : in_br_ext;
                s1_xi_d    = (in_mode == MODE_DIF) ? dif_i : in_bi_ext;
            end

            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_mode_d  = s1_mode_q;
                s2_scale_d = s1_scale_q;
                s2_ar_d    = s1_ar_q;
                s2_ai_d    = s1_ai_q;
                s2_br_d    = s1_br_q;
                s2_bi_d    = s1_bi_q;
                s2_mr_d    = mul_re;
                s2_mi_d    = mul_im;
            end

            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_0r_d  = WIDTH'(s0r);
                out_0i_d  = WIDTH'(s0i);
                out_1r_d  = WIDTH'(s1r);
                out_1i_d  = WIDTH'(s1i);
                out_sat_d = s3_clip;
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_mode_q    <= 1'b0;
            s1_scale_q   <= 1'b0;
            s1_ar_q      <= '0;
            s1_ai_q      <= '0;
            s1_br_q      <= '0;
            s1_bi_q      <= '0;
            s1_wr_q      <= '0;
            s1_wi_q      <= '0;
            s1_xr_q      <= '0;
            s1_xi_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_mode_q    <= 1'b0;
            s2_scale_q   <= 1'b0;
            s2_ar_q      <= '0;
            s2_ai_q      <= '0;
            s2_br_q      <= '0;
            s2_bi_q      <= '0;
            s2_mr_q      <= '0;
            s2_mi_q      <= '0;
            out_valid_q  <= 1'b0;
            out_0r_q     <= '0;
            out_0i_q     <= '0;
            out_1r_q     <= '0;
            out_1i_q     <= '0;
            out_sat_q    <= 1'b0;
            sat_sticky_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_mode_q    <= s1_mode_d;
            s1_scale_q   <= s1_scale_d;
            s1_ar_q      <= s1_ar_d;
            s1_ai_q      <= s1_ai_d;
            s1_br_q      <= s1_br_d;
            s1_bi_q      <= s1_bi_d;
            s1_wr_q      <= s1_wr_d;
            s1_wi_q      <= s1_wi_d;
            s1_xr_q      <= s1_xr_d;
            s1_xi_q      <= s1_xi_d;
            s2_valid_q   <= s2_valid_d;
            s2_mode_q    <= s2_mode_d;
            s2_scale_q   <= s2_scale_d;
            s2_ar_q      <= s2_ar_d;
            s2_ai_q      <= s2_ai_d;
            s2_br_q      <= s2_br_d;
            s2_bi_q      <= s2_bi_d;
            s2_mr_q      <= s2_mr_d;
            s2_mi_q      <= s2_mi_d;
            out_valid_q  <= out_valid_d;
            out_0r_q     <= out_0r_d;
            out_0i_q     <= out_0i_d;
            out_1r_q     <= out_1r_d;
            out_1i_q     <= out_1i_d;
            out_sat_q    <= out_sat_d;
            sat_sticky_q <= sat_sticky_d;
        end
    end

    // ---------------- outputs ----------------
    assign in_ready   = advance;
    assign out_valid  = out_valid_q;
    assign out_0r     = out_0r_q;
    assign out_0i     = out_0i_q;
    assign out_1r     = out_1r_q;
    assign out_1i     = out_1i_q;
    assign out_sat    = out_sat_q;
    assign sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
module tb_fft_butterfly_pipe;

    localparam int WIDTH = 8;
    localparam int FRAC  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, in_mode, in_scale;
    logic [7:0] in_ar, in_ai, in_br, in_bi, in_wr, in_wi;
    logic       out_valid, out_ready, out_sat, sat_sticky;
    logic [7:0] out_0r, out_0i, out_1r, out_1i;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int o0r;
        int o0i;
        int o1r;
        int o1i;
        bit sat;
    } exp_t;

    typedef struct {
        bit         mode;
        bit         scale;
        logic [7:0] ar, ai, br, bi, wr, wi;
        logic [7:0] o0r, o0i, o1r, o1i;
        bit         sat;
    } vec_t;

    exp_t exp_q[$];

    fft_butterfly_pipe #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_scale   (in_scale),
        .in_ar      (in_ar),
        .in_ai      (in_ai),
        .in_br      (in_br),
        .in_bi      (in_bi),
        .in_wr      (in_wr),
        .in_wi      (in_wi),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_0r     (out_0r),
        .out_0i     (out_0i),
        .out_1r     (out_1r),
        .out_1i     (out_1i),
        .out_sat    (out_sat),
        .sat_sticky (sat_sticky)
    );

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    // Floor division for a positive divisor.
    function automatic int fdiv(input int n, input int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic int rnd(input int p);
        return fdiv(p + 2 ** (FRAC - 1), 2 ** FRAC);
    endfunction

    function automatic exp_t model(input bit mode, input bit scale,
                                   input logic [7:0] ar, input logic [7:0] ai,
                                   input logic [7:0] br, input logic [7:0] bi,
                                   input logic [7:0] wr, input logic [7:0] wi);
        exp_t e;
        int   r[4];
        int   a_r, a_i, b_r, b_i, w_r, w_i, dr, di, mr, mi;
        int   hi, lo;
        a_r = sx(ar); a_i = sx(ai); b_r = sx(br); b_i = sx(bi); w_r = sx(wr); w_i = sx(wi);
        hi  = 2 ** (WIDTH - 1) - 1;
        lo  = -(2 ** (WIDTH - 1));
        if (!mode) begin
            mr   = rnd(b_r * w_r - b_i * w_i);
            mi   = rnd(b_r * w_i + b_i * w_r);
            r[0] = a_r + mr;
            r[1] = a_i + mi;
            r[2] = a_r - mr;
            r[3] = a_i - mi;
        end else begin
            dr   = a_r - b_r;
            di   = a_i - b_i;
            r[0] = a_r + b_r;
            r[1] = a_i + b_i;
            r[2] = rnd(dr * w_r - di * w_i);
            r[3] = rnd(dr * w_i + di * w_r);
        end
        e.sat = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (scale) r[k] = fdiv(r[k] + 1, 2);
            if (r[k] > hi) begin
                r[k]  = hi;
                e.sat = 1'b1;
            end else if (r[k] < lo) begin
                r[k]  = lo;
                e.sat = 1'b1;
            end
        end
        e.o0r = r[0]; e.o0i = r[1]; e.o1r = r[2]; e.o1i = r[3];
        return e;
    endfunction

    task automatic rand_inputs();
        in_ar    = 8'($urandom_range(0, 255));
        in_ai    = 8'($urandom_range(0, 255));
        in_br    = 8'($urandom_range(0, 255));
        in_bi    = 8'($urandom_range(0, 255));
        in_wr    = 8'($urandom_range(0, 255));
        in_wi    = 8'($urandom_range(0, 255));
        in_mode  = 1'($urandom_range(0, 1));
        in_scale = 1'($urandom_range(0, 1));
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        rand_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if ({out_0r, out_0i, out_1r, out_1i} !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {out_0r, out_0i, out_1r, out_1i});
        end
        checks++;
        if (out_sat !== 1'b0) begin
            errors++; $display("FAIL reset_sat: got %b expected 0", out_sat);
        end
        checks++;
        if (sat_sticky !== 1'b0) begin
            errors++; $display("FAIL reset_sticky: got %b expected 0", sat_sticky);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        vec_t v[7];
        v[0] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 8'h30, 8'h00, 8'h10, 8'h00, 1'b0};
        v[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'hF0, 8'h00, 8'hF0, 8'h00, 8'h10, 1'b0};
        v[2] = '{1'b0, 1'b0, 8'h70, 8'h00, 8'h70, 8'h00, 8'h10, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 1'b1};
        v[3] = '{1'b0, 1'b1, 8'h70, 8'h00, 8'h70, 8'h00, 8'h10, 8'h00, 8'h70, 8'h00, 8'h00, 8'h00, 1'b0};
        v[4] = '{1'b1, 1'b0, 8'h30, 8'h10, 8'h10, 8'h10, 8'h00, 8'hF0, 8'h40, 8'h20, 8'h00, 8'hE0, 1'b0};
        v[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h18, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'hFE, 8'h00, 1'b0};
        v[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hE8, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h00, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1; in_valid = 1'b1;
            in_mode = v[i].mode; in_scale = v[i].scale;
            in_ar = v[i].ar; in_ai = v[i].ai; in_br = v[i].br;
            in_bi = v[i].bi; in_wr = v[i].wr; in_wi = v[i].wi;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL vec%0d_accept: got in_ready=%b expected 1", i, in_ready);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            rand_inputs();
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL vec%0d_early: got out_valid=%b expected 0", i, out_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL vec%0d_latency: got out_valid=%b expected 1", i, out_valid);
            end
            checks++;
            if ({out_0r, out_0i, out_1r, out_1i} !== {v[i].o0r, v[i].o0i, v[i].o1r, v[i].o1i}) begin
                errors++;
                $display("FAIL vec%0d_data: got %h %h %h %h expected %h %h %h %h", i,
                         out_0r, out_0i, out_1r, out_1i, v[i].o0r, v[i].o0i, v[i].o1r, v[i].o1i);
            end
            checks++;
            if (out_sat !== v[i].sat) begin
                errors++; $display("FAIL vec%0d_sat: got %b expected %b", i, out_sat, v[i].sat);
            end
            if (i == 2) begin
                checks++;
                if (sat_sticky !== 1'b0) begin
                    errors++; $display("FAIL sticky_before_hs: got %b expected 0", sat_sticky);
                end
                @(posedge clk); #1;
                checks++;
                if (sat_sticky !== 1'b1) begin
                    errors++; $display("FAIL sticky_after_hs: got %b expected 1", sat_sticky);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int          sent  = 0;
        int          got   = 0;
        int          stall = -1;
        bit          held  = 1'b0;
        logic [32:0] held_val;
        exp_t        e;
        out_ready = 1'b1; in_valid = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            @(posedge clk); #1;
            if (out_valid && stall < 0) stall = 5;
            out_ready = !(stall > 0);
            rand_inputs();
            in_valid = (sent < 6);
            in_mode  = sent[0];
            #1;
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready);
                end
                if (held) begin
                    checks++;
                    if ({out_sat, out_0r, out_0i, out_1r, out_1i} !== held_val) begin
                        errors++;
                        $display("FAIL bp_stable: got %h expected %h",
                                 {out_sat, out_0r, out_0i, out_1r, out_1i}, held_val);
                    end
                end
                held     = 1'b1;
                held_val = {out_sat, out_0r, out_0i, out_1r, out_1i};
            end else begin
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got unexpected output expected none");
                end else begin
                    e = exp_q.pop_front();
                    if (sx(out_0r) !== e.o0r || sx(out_0i) !== e.o0i || sx(out_1r) !== e.o1r ||
                        sx(out_1i) !== e.o1i || out_sat !== e.sat) begin
                        errors++;
                        $display("FAIL bp_data: got %0d %0d %0d %0d sat=%b expected %0d %0d %0d %0d sat=%b",
                                 sx(out_0r), sx(out_0i), sx(out_1r), sx(out_1i), out_sat,
                                 e.o0r, e.o0i, e.o1r, e.o1i, e.sat);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_mode, in_scale, in_ar, in_ai, in_br, in_bi, in_wr, in_wi));
                sent++;
            end
            if (stall > 0) stall--;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 6 || exp_q.size() !== 0) begin
            errors++; $display("FAIL bp_count: got %0d outputs expected 6 (pending %0d)", got, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_random_stream();
        bit          held = 1'b0;
        logic [32:0] held_val;
        exp_t        e;
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(posedge clk); #1;
            rand_inputs();
            in_valid  = (cyc < 400) && ($urandom_range(0, 3) != 0);
            out_ready = (cyc >= 400) || ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL rs_in_ready: got %b expected %b", in_ready, !out_valid || out_ready);
            end
            if (out_valid && held) begin
                checks++;
                if ({out_sat, out_0r, out_0i, out_1r, out_1i} !== held_val) begin
                    errors++;
                    $display("FAIL rs_stable: got %h expected %h",
                             {out_sat, out_0r, out_0i, out_1r, out_1i}, held_val);
                end
            end
            held     = out_valid && !out_ready;
            held_val = {out_sat, out_0r, out_0i, out_1r, out_1i};
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rs_extra: got unexpected output expected none");
                end else begin
                    e = exp_q.pop_front();
                    if (sx(out_0r) !== e.o0r || sx(out_0i) !== e.o0i || sx(out_1r) !== e.o1r ||
                        sx(out_1i) !== e.o1i || out_sat !== e.sat) begin
                        errors++;
                        $display("FAIL rs_data: got %0d %0d %0d %0d sat=%b expected %0d %0d %0d %0d sat=%b",
                                 sx(out_0r), sx(out_0i), sx(out_1r), sx(out_1i), out_sat,
                                 e.o0r, e.o0i, e.o1r, e.o1i, e.sat);
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_mode, in_scale, in_ar, in_ai, in_br, in_bi, in_wr, in_wi));
        end
        in_valid = 1'b0;
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL rs_drain: got %0d pending expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_stream();
        int seen = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_mode = 1'b0; in_scale = 1'b0;
            in_ar = 8'h70; in_ai = 8'h00; in_br = 8'h70; in_bi = 8'h00;
            in_wr = 8'h10; in_wi = 8'h00;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_inflight: got out_valid=%b expected 1", out_valid);
        end
        rst = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (sat_sticky !== 1'b0) begin
            errors++; $display("FAIL mid_sticky: got %b expected 0", sat_sticky);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL mid_flushed: got %0d outputs expected 0", seen);
        end
        checks++;
        if (sat_sticky !== 1'b0) begin
            errors++; $display("FAIL mid_sticky_end: got %b expected 0", sat_sticky);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_mode = 1'b0; in_scale = 1'b0;
        in_ar = '0; in_ai = '0; in_br = '0; in_bi = '0; in_wr = '0; in_wi = '0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_random_stream();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
